// File: rtl/mult_div_ctrl.sv
// mult_div_ctrl -- iterative signed multiply / divide unit with HI/LO result registers.
//
// The unit takes one operation at a time. It works on operand magnitudes one bit
// per cycle (shift-add for multiply, restoring division for divide) and then
// applies the sign in a single fix-up cycle. A request takes WIDTH+2 cycles from
// its acceptance edge to the next acceptance edge. A divide by zero returns after
// one cycle with only the div_zero flag set.
//
// Ports
//   clk       rising-edge clock
//   reset     asynchronous active-low reset
//   start     operation request, sampled only while idle
//   op        0 = signed multiply, 1 = signed divide
//   a, b      multiplicand/dividend, multiplier/divisor (two's complement)
//   busy      high while an operation is in flight
//   done      one-cycle completion pulse
//   div_zero  one-cycle pulse with done when the divisor is zero
//   hi, lo    registered results (product upper/lower, or remainder/quotient)
//   hi_w      HI write strobe, pulses with done on a normal completion
//   lo_w      LO write strobe, pulses with done on a normal completion
module mult_div_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             hi_w,
  output logic             lo_w
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MULT = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_FIX  = 2'd3;

  localparam logic [5:0] LAST_CNT = 6'(WIDTH - 1);

  logic [1:0]         state;
  logic [5:0]         cnt;

  // Captured operation and working registers. These carry no reset: they are
  // always loaded at the acceptance edge before anything reads them.
  logic               op_r;
  logic               neg_q;
  logic               neg_r;
  logic [WIDTH-1:0]   opr;
  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   lsw;

  logic [WIDTH-1:0]   mul_addend;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic               div_ge;
  logic [WIDTH-1:0]   div_diff;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

  // Magnitude of a two's complement value. The most negative value maps onto
  // itself, which read as unsigned is exactly its magnitude.
  function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v);
    return v[WIDTH-1] ? -v : v;
  endfunction

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] cond_neg2(input logic [2*WIDTH-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  assign busy = (state != S_IDLE);

  always_comb begin
    // Shift-add step: add the multiplicand when the current multiplier bit is set.
    mul_addend = lsw[0] ? opr : '0;
    mul_sum    = {1'b0, acc} + {1'b0, mul_addend};
    // Restoring step: the shifted partial remainder is below twice the divisor,
    // so it fits in WIDTH+1 bits and a successful difference fits in WIDTH bits.
    div_shift  = {acc, lsw[WIDTH-1]};
    div_ge     = (div_shift >= {1'b0, opr});
    div_diff   = div_shift[WIDTH-1:0] - opr;
    // Sign fix-up: quotient/product take the XOR of the operand signs, the
    // remainder takes the dividend sign.
    prod_fix   = cond_neg2({acc, lsw}, neg_q);
    if (op_r) begin
      fix_hi = cond_neg(acc, neg_r);
      fix_lo = cond_neg(lsw, neg_q);
    end else begin
      fix_hi = prod_fix[2*WIDTH-1:WIDTH];
      fix_lo = prod_fix[WIDTH-1:0];
    end
  end

  // Control and architectural results.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi_w     <= 1'b0;
      lo_w     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi_w     <= 1'b0;
      lo_w     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= op ? S_DIV : S_MULT;
            cnt   <= '0;
          end
        end
        S_MULT: begin
          cnt <= cnt + 6'd1;
          if (cnt == LAST_CNT) state <= S_FIX;
        end
        S_DIV: begin
          if (opr == '0) begin
            // Zero divisor: report and return without touching hi/lo.
            state    <= S_IDLE;
            done     <= 1'b1;
            div_zero <= 1'b1;
          end else begin
            cnt <= cnt + 6'd1;
            if (cnt == LAST_CNT) state <= S_FIX;
          end
        end
        S_FIX: begin
          state <= S_IDLE;
          done  <= 1'b1;
          hi_w  <= 1'b1;
          lo_w  <= 1'b1;
          hi    <= fix_hi;
          lo    <= fix_lo;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Iterative datapath.
  always_ff @(posedge clk) begin
    case (state)
      S_IDLE: begin
        if (start) begin
          op_r  <= op;
          neg_q <= a[WIDTH-1] ^ b[WIDTH-1];
          neg_r <= a[WIDTH-1];
          acc   <= '0;
          // Multiply: opr = multiplicand, lsw = multiplier.
          // Divide:   opr = divisor,      lsw = dividend (becomes the quotient).
          opr   <= op ? mag(b) : mag(a);
          lsw   <= op ? mag(a) : mag(b);
        end
      end
      S_MULT: begin
        acc <= mul_sum[WIDTH:1];
        lsw <= {mul_sum[0], lsw[WIDTH-1:1]};
      end
      S_DIV: begin
        if (div_ge) begin
          acc <= div_diff;
          lsw <= {lsw[WIDTH-2:0], 1'b1};
        end else begin
          acc <= div_shift[WIDTH-1:0];
          lsw <= {lsw[WIDTH-2:0], 1'b0};
        end
      end
      default: ;
    endcase
  end

endmodule
